m_axi_single_master: RTL and testbench
======================================

// Module: m_axi_single_master
// PURPOSE
//  Single-outstanding AXI master feeding the s_axi_reg register slave of the counter subsystem.
//  Turns one command (write or read, one 32-bit beat) from a local valid/ready port into AXI AW/W/B or AR/R traffic.
//  Returns one response per command on a local response port.
//  Sits directly upstream of the register slave; also drives its reads for readback/debug.
// PARAMETERS
//  ADDR_W          32   AXI address width
//  DATA_W          32   data width; WSTRB width = DATA_W/8
//  ID_W            4    AXI ID width
//  TIMEOUT_CYCLES  256  watchdog limit in clk cycles; used only with M_AXI_TIMEOUT_EN
// PORTS
//  clk           in   1          system clock, all logic on rising edge
//  areset        in   1          asynchronous reset, active-high
//  cmd_valid_i   in   1          command valid
//  cmd_ready_o   out  1          command accepted when valid&ready
//  cmd_write_i   in   1          1=write, 0=read
//  cmd_id_i      in   ID_W       transaction ID
//  cmd_addr_i    in   ADDR_W     target address, passed through unchanged
//  cmd_wdata_i   in   DATA_W     write data
//  cmd_wstrb_i   in   DATA_W/8   write byte strobes
//  rsp_valid_o   out  1          response valid
//  rsp_ready_i   in   1          response consumed when valid&ready
//  rsp_write_o   out  1          response belongs to a write
//  rsp_id_o      out  ID_W       ID of the completed command
//  rsp_rdata_o   out  DATA_W     read data; 0 for writes
//  rsp_resp_o    out  2          00 OKAY, 10 ID mismatch, 11 timeout
//  awid_o/awaddr_o/awvalid_o out, awready_i in   AXI write address channel
//  wid_o/wdata_o/wstrb_o/wlast_o/wvalid_o out, wready_i in   AXI write data channel
//  bid_i in ID_W, bresp_i in 2, bvalid_i in 1, bready_o out 1   AXI write response channel
//  arid_o/araddr_o/arvalid_o out, arready_i in   AXI read address channel
//  rid_i in ID_W, rdata_i in DATA_W, rlast_i in 1, rvalid_i in 1, rready_o out 1   AXI read data channel
// BEHAVIOUR
//  Reset: state=IDLE. All valid/ready outputs are 0 except cmd_ready_o=1. All data, addr, ID and resp outputs are 0.
//  Reset mid-transaction drops every valid output immediately and asynchronously.
//  FSM states: IDLE, WR_REQ, WR_RESP, RD_REQ, RD_DATA, RSP.
//   IDLE: cmd_ready_o=1. On cmd handshake, register id/addr/wdata/wstrb.
//     Next state is WR_REQ if write, RD_REQ if read.
//   WR_REQ: awvalid_o and wvalid_o rise together, 1 cycle after command accept. wlast_o=1 whenever wvalid_o=1.
//     Each channel drops its valid on its own handshake; aw_done/w_done flags track completion.
//     AW and W may complete in either order or in the same cycle.
//     Leave for WR_RESP the cycle after both are done. Valids never drop before their handshake.
//   WR_RESP: bready_o=1. On bvalid_i, capture resp and go to RSP.
//     resp = 10 if bid_i!=stored id, else bresp_i.
//   RD_REQ: arvalid_o=1 until arready_i handshake, then go to RD_DATA.
//   RD_DATA: rready_o=1. On rvalid_i, capture rdata_i and go to RSP.
//     resp = 10 if rid_i!=stored id; rlast_i is required to be 1, otherwise resp=10.
//   RSP: rsp_valid_o=1 with fields held stable. On rsp_ready_i, go to IDLE.
//     Next command can be accepted the following cycle.
//  Minimum latency: command accept to rsp_valid_o is 3 cycles for a write and 3 cycles for a read, with zero-wait slave.
//  bready_o and rready_o are 0 outside their states (except as noted under CONFIGURATION).
//  Exactly one transaction outstanding; cmd_ready_o=0 whenever state!=IDLE.
//  awid_o=wid_o=arid_o=stored id. Address/data outputs hold the stored values from accept until the next accept.
// CONFIGURATION
//  M_AXI_TIMEOUT_EN defined:
//   - Cycle counter runs in WR_REQ, WR_RESP, RD_REQ and RD_DATA; cleared on each state entry.
//   - At TIMEOUT_CYCLES it drops all AXI valids, sets resp=11 with rdata=0, and goes to RSP.
//   - In IDLE and RSP, bready_o=rready_o=1 so late responses are drained and discarded.
//  M_AXI_TIMEOUT_EN undefined: no counter and no 11 response; the FSM waits indefinitely.
// STRUCTURE
//  Package m_axi_pkg: state_t enum; RESP_OKAY=2'b00, RESP_IDERR=2'b10, RESP_TMO=2'b11; default width localparams.
//  Sub-module axi_watchdog (counter, clear, expire pulse), instantiated only under M_AXI_TIMEOUT_EN.
//  Everything else lives in this module.
// TESTING
//  1. Write id=3 addr=2 data=0xDEADBEEF strb=0xF, zero-wait slave
//     -> AW/W handshake same cycle; rsp at accept+3; write=1, id=3, resp=00.
//  2. Write where awready is delayed 4 cycles and wready arrives first
//     -> wvalid drops after its handshake, awvalid stays high; single B accepted; resp=00.
//  3. Read id=5 addr=2 after test 1 -> rsp rdata=0xDEADBEEF, id=5, resp=00, write=0.
//  4. Slave returns bid=4 for a command with id=3 -> rsp_resp_o=10.
//     Next command is accepted normally.
//  5. rsp_ready_i held low 10 cycles -> rsp fields are stable and cmd_ready_o=0 throughout.
//     Assert areset during WR_REQ -> awvalid_o, wvalid_o and rsp_valid_o go to 0 at once.
//  6. With M_AXI_TIMEOUT_EN and TIMEOUT_CYCLES=16, slave never asserts arready
//     -> arvalid drops after 16 cycles; rsp resp=11, rdata=0.
//     A late rvalid is drained with no second rsp.

Source files
------------

// File: rtl/m_axi_pkg.sv
// rtl/m_axi_pkg.sv - shared types and constants for m_axi_single_master
package m_axi_pkg;

  typedef enum logic [2:0] {
    IDLE,
    WR_REQ,
    WR_RESP,
    RD_REQ,
    RD_DATA,
    RSP
  } state_t;

  localparam logic [1:0] RESP_OKAY  = 2'b00;
  localparam logic [1:0] RESP_IDERR = 2'b10;
  localparam logic [1:0] RESP_TMO   = 2'b11;

  localparam int DEF_ADDR_W         = 32;
  localparam int DEF_DATA_W         = 32;
  localparam int DEF_ID_W           = 4;
  localparam int DEF_TIMEOUT_CYCLES = 256;

endpackage

// File: rtl/axi_watchdog.sv
// rtl/axi_watchdog.sv - stall counter for m_axi_single_master (used with M_AXI_TIMEOUT_EN)
module axi_watchdog #(
  parameter int LIMIT = 256
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic run,
  output logic expire
);

  localparam int            CW   = (LIMIT > 1) ? $clog2(LIMIT) : 1;
  localparam logic [CW-1:0] LAST = CW'(LIMIT - 1);

  logic [CW-1:0] count;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (clear || !run) begin
      count <= '0;
    end else if (count != LAST) begin
      count <= count + 1'b1;
    end
  end

  // Pulses in the LIMIT-th cycle of a state, so valids stay up exactly LIMIT cycles.
  assign expire = run && (count == LAST);

endmodule

// File: rtl/m_axi_single_master.sv
// rtl/m_axi_single_master.sv - single-outstanding AXI master for the s_axi_reg slave
// Optional stall watchdog and late-response draining enabled by M_AXI_TIMEOUT_EN.
module m_axi_single_master
  import m_axi_pkg::*;
#(
  parameter int ADDR_W         = DEF_ADDR_W,
  parameter int DATA_W         = DEF_DATA_W,
  parameter int ID_W           = DEF_ID_W,
  parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
  input  logic                clk,
  input  logic                areset,
  input  logic                cmd_valid_i,
  output logic                cmd_ready_o,
  input  logic                cmd_write_i,
  input  logic [ID_W-1:0]     cmd_id_i,
  input  logic [ADDR_W-1:0]   cmd_addr_i,
  input  logic [DATA_W-1:0]   cmd_wdata_i,
  input  logic [DATA_W/8-1:0] cmd_wstrb_i,
  output logic                rsp_valid_o,
  input  logic                rsp_ready_i,
  output logic                rsp_write_o,
  output logic [ID_W-1:0]     rsp_id_o,
  output logic [DATA_W-1:0]   rsp_rdata_o,
  output logic [1:0]          rsp_resp_o,
  output logic [ID_W-1:0]     awid_o,
  output logic [ADDR_W-1:0]   awaddr_o,
  output logic                awvalid_o,
  input  logic                awready_i,
  output logic [ID_W-1:0]     wid_o,
  output logic [DATA_W-1:0]   wdata_o,
  output logic [DATA_W/8-1:0] wstrb_o,
  output logic                wlast_o,
  output logic                wvalid_o,
  input  logic                wready_i,
  input  logic [ID_W-1:0]     bid_i,
  input  logic [1:0]          bresp_i,
  input  logic                bvalid_i,
  output logic                bready_o,
  output logic [ID_W-1:0]     arid_o,
  output logic [ADDR_W-1:0]   araddr_o,
  output logic                arvalid_o,
  input  logic                arready_i,
  input  logic [ID_W-1:0]     rid_i,
  input  logic [DATA_W-1:0]   rdata_i,
  input  logic                rlast_i,
  input  logic                rvalid_i,
  output logic                rready_o
);

  state_t              state, state_next;
  logic                aw_done, w_done;
  logic                write_q;
  logic [ID_W-1:0]     id_q;
  logic [ADDR_W-1:0]   addr_q;
  logic [DATA_W-1:0]   wdata_q, rdata_q;
  logic [DATA_W/8-1:0] wstrb_q;
  logic [1:0]          resp_q;
  logic                tmo_expire, tmo_fire;

  if (TIMEOUT_CYCLES < 1) begin : g_timeout_cycles_must_be_positive
  end

  always_ff @(posedge clk or posedge areset) begin
    if (areset) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next  = state;
    cmd_ready_o = 1'b0;
    awvalid_o   = 1'b0;
    wvalid_o    = 1'b0;
    bready_o    = 1'b0;
    arvalid_o   = 1'b0;
    rready_o    = 1'b0;
    rsp_valid_o = 1'b0;
    tmo_fire    = 1'b0;
    case (state)
      IDLE: begin
        cmd_ready_o = 1'b1;
        if (cmd_valid_i) state_next = cmd_write_i ? WR_REQ : RD_REQ;
      end
      WR_REQ: begin
        awvalid_o = !aw_done;
        wvalid_o  = !w_done;
        if ((aw_done || awready_i) && (w_done || wready_i)) state_next = WR_RESP;
      end
      WR_RESP: begin
        bready_o = 1'b1;
        if (bvalid_i) state_next = RSP;
      end
      RD_REQ: begin
        arvalid_o = 1'b1;
        if (arready_i) state_next = RD_DATA;
      end
      RD_DATA: begin
        rready_o = 1'b1;
        if (rvalid_i) state_next = RSP;
      end
      RSP: begin
        rsp_valid_o = 1'b1;
        if (rsp_ready_i) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
    // A real completion in the expiry cycle wins over the timeout.
    if (tmo_expire && state_next == state) begin
      tmo_fire   = 1'b1;
      state_next = RSP;
    end
`ifdef M_AXI_TIMEOUT_EN
    if (state == IDLE || state == RSP) begin
      bready_o = 1'b1;
      rready_o = 1'b1;
    end
`endif
  end

  always_ff @(posedge clk or posedge areset) begin
    if (areset) begin
      aw_done <= 1'b0;
      w_done  <= 1'b0;
      write_q <= 1'b0;
      id_q    <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      wstrb_q <= '0;
      rdata_q <= '0;
      resp_q  <= RESP_OKAY;
    end else begin
      if (state == IDLE && cmd_valid_i) begin
        aw_done <= 1'b0;
        w_done  <= 1'b0;
        write_q <= cmd_write_i;
        id_q    <= cmd_id_i;
        addr_q  <= cmd_addr_i;
        wdata_q <= cmd_wdata_i;
        wstrb_q <= cmd_wstrb_i;
        rdata_q <= '0;
        resp_q  <= RESP_OKAY;
      end
      if (state == WR_REQ && awready_i) aw_done <= 1'b1;
      if (state == WR_REQ && wready_i)  w_done  <= 1'b1;
      if (state == WR_RESP && bvalid_i) begin
        resp_q <= (bid_i != id_q) ? RESP_IDERR : bresp_i;
      end
      if (state == RD_DATA && rvalid_i) begin
        rdata_q <= rdata_i;
        resp_q  <= (rid_i != id_q || !rlast_i) ? RESP_IDERR : RESP_OKAY;
      end
      if (tmo_fire) begin
        resp_q  <= RESP_TMO;
        rdata_q <= '0;
      end
    end
  end

`ifdef M_AXI_TIMEOUT_EN
  logic tmo_run;
  assign tmo_run = (state == WR_REQ) || (state == WR_RESP) ||
                   (state == RD_REQ) || (state == RD_DATA);

  axi_watchdog #(
    .LIMIT(TIMEOUT_CYCLES)
  ) u_watchdog (
    .clk   (clk),
    .rst   (areset),
    .clear (state_next != state),
    .run   (tmo_run),
    .expire(tmo_expire)
  );
`else
  assign tmo_expire = 1'b0;
`endif

  assign awid_o      = id_q;
  assign wid_o       = id_q;
  assign arid_o      = id_q;
  assign awaddr_o    = addr_q;
  assign araddr_o    = addr_q;
  assign wdata_o     = wdata_q;
  assign wstrb_o     = wstrb_q;
  assign wlast_o     = wvalid_o;
  assign rsp_write_o = write_q;
  assign rsp_id_o    = id_q;
  assign rsp_rdata_o = rdata_q;
  assign rsp_resp_o  = resp_q;

endmodule

// File: tb/tb_m_axi_single_master.sv
// tb/tb_m_axi_single_master.sv - directed bench for m_axi_single_master with a reactive AXI slave
module tb_m_axi_single_master;

`ifdef M_AXI_TIMEOUT_EN
  localparam logic TMO_EN = 1'b1;
`else
  localparam logic TMO_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        areset;
  logic        cmd_valid_i, cmd_ready_o, cmd_write_i;
  logic [3:0]  cmd_id_i;
  logic [31:0] cmd_addr_i, cmd_wdata_i;
  logic [3:0]  cmd_wstrb_i;
  logic        rsp_valid_o, rsp_ready_i, rsp_write_o;
  logic [3:0]  rsp_id_o;
  logic [31:0] rsp_rdata_o;
  logic [1:0]  rsp_resp_o;
  logic [3:0]  awid_o, wid_o, arid_o, bid_i, rid_i;
  logic [31:0] awaddr_o, araddr_o, wdata_o, rdata_i;
  logic [3:0]  wstrb_o;
  logic        awvalid_o, awready_i, wlast_o, wvalid_o, wready_i;
  logic [1:0]  bresp_i;
  logic        bvalid_i, bready_o, arvalid_o, arready_i, rlast_i, rvalid_i, rready_o;

  int errors = 0;
  int checks = 0;
  int cyc    = 0;

  logic [31:0] mem [0:15];
  int          aw_delay = 0;
  logic        ar_enable = 1'b1;
  logic        bid_force_en = 1'b0;
  logic [3:0]  bid_force = 4'd0;
  logic        got_aw = 1'b0, got_w = 1'b0, b_pending = 1'b0, r_pending = 1'b0, r_inject = 1'b0;
  logic [3:0]  aw_addr = 4'd0, r_addr = 4'd0, b_id = 4'd0, r_id = 4'd0, w_strb = 4'd0;
  logic [31:0] w_data = 32'd0;
  logic        wlast_seen = 1'b0;
  int          aw_cnt = 0, aw_valid_cycles = 0, w_valid_cycles = 0, ar_valid_cycles = 0;
  int          b_hs_count = 0, aw_hs_cyc = 0, w_hs_cyc = 0;

  m_axi_single_master #(
    .ADDR_W(32), .DATA_W(32), .ID_W(4), .TIMEOUT_CYCLES(16)
  ) dut (
    .clk(clk), .areset(areset),
    .cmd_valid_i(cmd_valid_i), .cmd_ready_o(cmd_ready_o), .cmd_write_i(cmd_write_i),
    .cmd_id_i(cmd_id_i), .cmd_addr_i(cmd_addr_i), .cmd_wdata_i(cmd_wdata_i), .cmd_wstrb_i(cmd_wstrb_i),
    .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready_i), .rsp_write_o(rsp_write_o),
    .rsp_id_o(rsp_id_o), .rsp_rdata_o(rsp_rdata_o), .rsp_resp_o(rsp_resp_o),
    .awid_o(awid_o), .awaddr_o(awaddr_o), .awvalid_o(awvalid_o), .awready_i(awready_i),
    .wid_o(wid_o), .wdata_o(wdata_o), .wstrb_o(wstrb_o), .wlast_o(wlast_o),
    .wvalid_o(wvalid_o), .wready_i(wready_i),
    .bid_i(bid_i), .bresp_i(bresp_i), .bvalid_i(bvalid_i), .bready_o(bready_o),
    .arid_o(arid_o), .araddr_o(araddr_o), .arvalid_o(arvalid_o), .arready_i(arready_i),
    .rid_i(rid_i), .rdata_i(rdata_i), .rlast_i(rlast_i), .rvalid_i(rvalid_i), .rready_o(rready_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Slave model: decides readies/valids at each falling edge; a handshake lands on the next rising edge.
  initial begin
    awready_i = 1'b0; wready_i = 1'b0; bvalid_i = 1'b0; bid_i = 4'd0; bresp_i = 2'd0;
    arready_i = 1'b0; rvalid_i = 1'b0; rid_i = 4'd0; rdata_i = 32'd0; rlast_i = 1'b0;
    for (int i = 0; i < 16; i++) mem[i] = 32'd0;
    forever begin
      @(negedge clk);
      cyc++;
      if (areset) begin
        awready_i = 1'b0; wready_i = 1'b0; bvalid_i = 1'b0; arready_i = 1'b0; rvalid_i = 1'b0;
        got_aw = 1'b0; got_w = 1'b0; b_pending = 1'b0; r_pending = 1'b0; aw_cnt = 0;
      end else begin
        bvalid_i = b_pending;
        bid_i    = bid_force_en ? bid_force : b_id;
        bresp_i  = 2'b00;
        if (bvalid_i && bready_o) begin
          b_pending = 1'b0;
          b_hs_count++;
        end
        if (r_inject) begin
          r_pending = 1'b1;
          r_inject  = 1'b0;
        end
        rvalid_i = r_pending;
        rid_i    = r_id;
        rdata_i  = mem[r_addr];
        rlast_i  = 1'b1;
        if (rvalid_i && rready_o) r_pending = 1'b0;
        awready_i = awvalid_o && (aw_cnt >= aw_delay);
        if (awvalid_o) begin
          aw_cnt++;
          aw_valid_cycles++;
        end else begin
          aw_cnt = 0;
        end
        if (awvalid_o && awready_i) begin
          got_aw = 1'b1; aw_addr = awaddr_o[3:0]; b_id = awid_o; aw_hs_cyc = cyc;
        end
        wready_i = wvalid_o;
        if (wvalid_o) w_valid_cycles++;
        if (wvalid_o && wready_i) begin
          got_w = 1'b1; w_data = wdata_o; w_strb = wstrb_o; w_hs_cyc = cyc; wlast_seen = wlast_o;
        end
        if (got_aw && got_w) begin
          for (int i = 0; i < 4; i++) if (w_strb[i]) mem[aw_addr][8*i +: 8] = w_data[8*i +: 8];
          got_aw = 1'b0; got_w = 1'b0; b_pending = 1'b1;
        end
        arready_i = arvalid_o && ar_enable;
        if (arvalid_o) ar_valid_cycles++;
        if (arvalid_o && arready_i) begin
          r_pending = 1'b1; r_addr = araddr_o[3:0]; r_id = arid_o;
        end
      end
    end
  end

  // Call at a falling edge; returns falling edges from accept until rsp_valid_o is seen.
  task automatic do_cmd(input logic wr, input logic [3:0] id, input logic [31:0] addr,
                        input logic [31:0] data, input logic [3:0] strb,
                        output int lat, output int wait_n);
    cmd_valid_i = 1'b1; cmd_write_i = wr; cmd_id_i = id;
    cmd_addr_i = addr; cmd_wdata_i = data; cmd_wstrb_i = strb;
    wait_n = 0;
    while (!cmd_ready_o && wait_n < 50) begin
      @(negedge clk);
      wait_n++;
    end
    @(negedge clk);
    cmd_valid_i = 1'b0;
    lat = 1;
    while (!rsp_valid_o && lat < 100) begin
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic release_rsp;
    rsp_ready_i = 1'b1;
    @(negedge clk);
    rsp_ready_i = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: got=running expected=finished");
    $fatal(1, "bench time limit reached");
  end

  initial begin
    int lat, wait_n, bad, extra;
    logic [31:0] cap_rdata;
    logic [3:0]  cap_id;
    logic [1:0]  cap_resp;

    areset = 1'b1; cmd_valid_i = 1'b0; cmd_write_i = 1'b0; cmd_id_i = 4'd0;
    cmd_addr_i = 32'd0; cmd_wdata_i = 32'd0; cmd_wstrb_i = 4'd0; rsp_ready_i = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_cmd_ready", 32'(cmd_ready_o), 32'd1);
    check("reset_awvalid",   32'(awvalid_o),   32'd0);
    check("reset_wvalid",    32'(wvalid_o),    32'd0);
    check("reset_arvalid",   32'(arvalid_o),   32'd0);
    check("reset_bready",    32'(bready_o),    32'(TMO_EN));
    check("reset_rsp_valid", 32'(rsp_valid_o), 32'd0);
    check("reset_rsp_resp",  32'(rsp_resp_o),  32'd0);
    check("reset_awaddr",    awaddr_o,         32'd0);
    areset = 1'b0;
    @(negedge clk);

    do_cmd(1'b1, 4'd3, 32'd2, 32'hDEADBEEF, 4'hF, lat, wait_n);
    check("t1_latency",  32'(lat),         32'd3);
    check("t1_write",    32'(rsp_write_o), 32'd1);
    check("t1_id",       32'(rsp_id_o),    32'd3);
    check("t1_resp",     32'(rsp_resp_o),  32'd0);
    check("t1_rdata",    rsp_rdata_o,      32'd0);
    check("t1_aw_w_same_cycle", 32'(aw_hs_cyc - w_hs_cyc), 32'd0);
    check("t1_wlast",    32'(wlast_seen),  32'd1);
    check("t1_mem",      mem[2],           32'hDEADBEEF);
    release_rsp();

    aw_delay = 4; aw_valid_cycles = 0; w_valid_cycles = 0; b_hs_count = 0;
    do_cmd(1'b1, 4'd1, 32'd4, 32'h12345678, 4'hF, lat, wait_n);
    check("t2_latency",       32'(lat),                   32'd7);
    check("t2_awvalid_cycles",32'(aw_valid_cycles),       32'd5);
    check("t2_wvalid_cycles", 32'(w_valid_cycles),        32'd1);
    check("t2_aw_after_w",    32'(aw_hs_cyc - w_hs_cyc),  32'd4);
    check("t2_b_count",       32'(b_hs_count),            32'd1);
    check("t2_resp",          32'(rsp_resp_o),            32'd0);
    check("t2_mem",           mem[4],                     32'h12345678);
    release_rsp();
    aw_delay = 0;

    do_cmd(1'b0, 4'd5, 32'd2, 32'd0, 4'h0, lat, wait_n);
    check("t3_latency", 32'(lat),         32'd3);
    check("t3_rdata",   rsp_rdata_o,      32'hDEADBEEF);
    check("t3_id",      32'(rsp_id_o),    32'd5);
    check("t3_resp",    32'(rsp_resp_o),  32'd0);
    check("t3_write",   32'(rsp_write_o), 32'd0);
    release_rsp();

    bid_force_en = 1'b1; bid_force = 4'd4;
    do_cmd(1'b1, 4'd3, 32'd6, 32'hA5A5A5A5, 4'h3, lat, wait_n);
    check("t4_resp_iderr", 32'(rsp_resp_o), 32'd2);
    check("t4_mem_strb",   mem[6],          32'h0000A5A5);
    release_rsp();
    bid_force_en = 1'b0;
    do_cmd(1'b0, 4'd7, 32'd4, 32'd0, 4'h0, lat, wait_n);
    check("t4_next_accept_wait", 32'(wait_n),       32'd0);
    check("t4_next_rdata",       rsp_rdata_o,       32'h12345678);
    check("t4_next_resp",        32'(rsp_resp_o),   32'd0);
    check("t4_next_id",          32'(rsp_id_o),     32'd7);
    release_rsp();

    do_cmd(1'b1, 4'd2, 32'd8, 32'hCAFEF00D, 4'hF, lat, wait_n);
    cap_rdata = rsp_rdata_o; cap_id = rsp_id_o; cap_resp = rsp_resp_o;
    check("t5_id", 32'(cap_id), 32'd2);
    bad = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (rsp_valid_o !== 1'b1 || cmd_ready_o !== 1'b0 || rsp_id_o !== cap_id ||
          rsp_rdata_o !== cap_rdata || rsp_resp_o !== cap_resp || rsp_write_o !== 1'b1) bad++;
    end
    check("t5_hold_stable", 32'(bad), 32'd0);
    release_rsp();

    cmd_valid_i = 1'b1; cmd_write_i = 1'b1; cmd_id_i = 4'd6; cmd_addr_i = 32'd10;
    cmd_wdata_i = 32'h11112222; cmd_wstrb_i = 4'hF;
    @(negedge clk);
    cmd_valid_i = 1'b0;
    check("t5_pre_awvalid", 32'(awvalid_o), 32'd1);
    check("t5_pre_wvalid",  32'(wvalid_o),  32'd1);
    areset = 1'b1;
    #1;
    check("t5_rst_awvalid",   32'(awvalid_o),   32'd0);
    check("t5_rst_wvalid",    32'(wvalid_o),    32'd0);
    check("t5_rst_rsp_valid", 32'(rsp_valid_o), 32'd0);
    check("t5_rst_cmd_ready", 32'(cmd_ready_o), 32'd1);
    @(negedge clk);
    @(negedge clk);
    areset = 1'b0;
    @(negedge clk);
    check("t5_post_rst_ready", 32'(cmd_ready_o), 32'd1);

`ifdef M_AXI_TIMEOUT_EN
    ar_enable = 1'b0; ar_valid_cycles = 0;
    do_cmd(1'b0, 4'd9, 32'd2, 32'd0, 4'h0, lat, wait_n);
    check("t6_latency",        32'(lat),             32'd17);
    check("t6_arvalid_cycles", 32'(ar_valid_cycles), 32'd16);
    check("t6_resp_tmo",       32'(rsp_resp_o),      32'd3);
    check("t6_rdata",          rsp_rdata_o,          32'd0);
    check("t6_id",             32'(rsp_id_o),        32'd9);
    release_rsp();
    ar_enable = 1'b1;
    r_id = 4'd9; r_addr = 4'd2; r_inject = 1'b1;
    extra = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (rsp_valid_o) extra++;
    end
    check("t6_no_second_rsp", 32'(extra),     32'd0);
    check("t6_late_r_drained", 32'(r_pending), 32'd0);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
